// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blank pattern and the supported digit-count range.
package seg7_pkg;

    localparam int DIGITS_MIN = 2;
    localparam int DIGITS_MAX = 8;

    // Cathode patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed with entry 15 first so HEX7_CODES[n] is the glyph for digit n.
    localparam logic [15:0][6:0] HEX7_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        return HEX7_CODES[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scan driver advanced by a synchronised slow clock.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_LZ_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
)
(
    input  logic                  cin,
    input  logic                  rst,
    input  logic                  slow_clk,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_valid,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
        $error("seg7_scan: DIGITS out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("seg7_scan: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [SYNC_STAGES-1:0] fill;
    logic                   s_sync;
    logic                   s_prev;
    logic                   primed;
    logic                   armed;
    logic                   tick;

    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_next;
    logic                   boundary;

    logic [4*DIGITS-1:0]    pend;
    logic                   pend_full;
    logic [4*DIGITS-1:0]    disp_reg;
    logic [4*DIGITS-1:0]    disp_next;

    logic [3:0]             sel_nib;
    logic [6:0]             hex_seg;
    logic [DIGITS-1:0]      lz;

    assign s_sync = sync_ff[SYNC_STAGES-1];
    assign primed = fill[SYNC_STAGES-1];

    // The fill chain marks when s_sync holds a real sample of slow_clk rather
    // than the reset zero, so a wave already high at release never looks like
    // a rising edge: ticks are only armed once a genuine low has been seen.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
            fill    <= '0;
            s_prev  <= 1'b0;
            armed   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], slow_clk};
            fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
            s_prev  <= s_sync;
            armed   <= armed | (primed & ~s_sync);
            tick    <= armed & s_sync & ~s_prev;
        end
    end

    always_comb begin
        idx_next = (idx == LAST) ? '0 : idx + IW'(1);
        boundary = tick & (idx == LAST);
    end

    // Contents the display shows after this cycle; a same-cycle strobe at a
    // boundary beats anything waiting in pend.
    always_comb begin
        disp_next = disp_reg;
        if (boundary) begin
            if (value_valid) begin
                disp_next = value;
            end else if (pend_full) begin
                disp_next = pend;
            end
        end
    end

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            idx       <= LAST;
            disp_reg  <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            disp_reg <= disp_next;
            if (tick) begin
                idx <= idx_next;
            end
            if (boundary) begin
                pend_full <= 1'b0;
            end else if (value_valid) begin
                pend      <= value;
                pend_full <= 1'b1;
            end
        end
    end

    assign sel_nib = disp_next[{idx_next, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (sel_nib),
        .seg    (hex_seg)
    );

`ifdef SEG7_BLANK_LZ_EN
    // A digit blanks while it and every digit to its left are zero.
    always_comb begin : lz_scan
        logic zero_run;
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (disp_next[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                an  <= ~(DIGITS'(1) << idx_next);
                seg <= lz[idx_next] ? SEG_BLANK : hex_seg;
                dp  <= ~dp_mask[idx_next];
            end
        end
    end

endmodule
